ntt_rom_sched: RTL and testbench

NTT_ROM_SCHED -- requirements
Module: ntt_rom_sched

---
 rtl/ntt_pkg.sv | 35 +++
 rtl/ntt_pair_fifo.sv | 47 ++++
 rtl/ntt_rom_sched.sv | 126 ++++++++++++
 tb/tb_ntt_rom_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly address scheduler: ROM geometry,
// scheduler state encoding and butterfly address helpers.
package ntt_pkg;

  localparam int AW   = 8;
  localparam int N    = 256;
  localparam int LOGN = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } sched_state_t;

  // Butterfly half-span for stage s: 1 << (7-s).
  function automatic logic [AW-1:0] bfly_half(input logic [2:0] s);
    logic [3:0] sh;
    sh = 4'd7 - {1'b0, s};
    return 8'd1 << sh;
  endfunction

  // Lower address of butterfly k in stage s: k's high bits are spread by one
  // position to leave room for the half-span bit, low bits stay in place.
  function automatic logic [AW-1:0] bfly_addr1(input logic [2:0] s, input logic [6:0] k);
    logic [3:0]    sh;
    logic [AW-1:0] kk;
    logic [AW-1:0] h;
    sh = 4'd7 - {1'b0, s};
    kk = {1'b0, k};
    h  = 8'd1 << sh;
    return ((kk >> sh) << (sh + 4'd1)) | (kk & (h - 8'd1));
  endfunction

endpackage

// File: rtl/ntt_pair_fifo.sv
// Two-entry operand-pair FIFO with same-edge push/pop and a synchronous flush.
module ntt_pair_fifo
  import ntt_pkg::*;
#(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ntt_rom_sched.sv
// NTT butterfly scheduler: walks (stage, k), reads both operands from an
// external dual-port ROM and hands the pairs out over a valid/ready port.
module ntt_rom_sched
  import ntt_pkg::*;
#(
  parameter int STAGES = 8,
  parameter int DW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rom_addr1,
  output logic [AW-1:0] rom_addr2,
  input  logic [DW-1:0] rom_a,
  input  logic [DW-1:0] rom_b,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [2:0]    out_stage,
  output logic [6:0]    out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int TW = 2*DW + 10;
  localparam logic [2:0] LAST_STAGE = 3'(STAGES - 1);

  sched_state_t state, state_nx;

  logic [2:0]    s_cnt;
  logic [6:0]    k_cnt;
  logic          inflight;
  logic [9:0]    tag_q;
  logic [1:0]    occ;
  logic [TW-1:0] head;
  logic          pop;
  logic          issue;
  logic          last_issue;
  logic          drained;

  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid && out_ready;

  // Occupancy plus the read still in flight bounds the FIFO at two entries.
  assign issue      = (state == ST_RUN) &&
                      ((({1'b0, occ} + {2'b0, inflight}) < 3'd2) || pop);
  assign last_issue = issue && (s_cnt == LAST_STAGE) && (k_cnt == 7'd127);
  // True when this edge removes the last buffered pair with nothing behind it.
  assign drained    = !inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (start)      state_nx = ST_RUN;
        ST_RUN:   if (last_issue) state_nx = ST_DRAIN;
        ST_DRAIN: if (drained)    state_nx = ST_DONE;
        ST_DONE:                  state_nx = ST_IDLE;
        default:                  state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt <= 3'd0;
      k_cnt <= 7'd0;
    end else if (abort || (state == ST_IDLE)) begin
      s_cnt <= 3'd0;
      k_cnt <= 7'd0;
    end else if (issue) begin
      k_cnt <= k_cnt + 7'd1;
      if (k_cnt == 7'd127) s_cnt <= s_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      tag_q    <= '0;
    end else if (abort) begin
      inflight <= 1'b0;
      tag_q    <= '0;
    end else begin
      inflight <= issue;
      if (issue) tag_q <= {s_cnt, k_cnt};
    end
  end

  ntt_pair_fifo #(.W(TW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (inflight),
    .din   ({rom_a, rom_b, tag_q}),
    .pop   (pop),
    .head  (head),
    .count (occ)
  );

  always_comb begin
    rom_addr1 = '0;
    rom_addr2 = '0;
    if (state == ST_RUN) begin
      rom_addr1 = bfly_addr1(s_cnt, k_cnt);
      rom_addr2 = rom_addr1 | bfly_half(s_cnt);
    end
  end

  assign out_a     = out_valid ? head[TW-1 -: DW]    : '0;
  assign out_b     = out_valid ? head[TW-DW-1 -: DW] : '0;
  assign out_stage = out_valid ? head[9:7]           : '0;
  assign out_idx   = out_valid ? head[6:0]           : '0;
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_ntt_rom_sched.sv
// Self-checking bench for ntt_rom_sched with STAGES=8 and STAGES=1 instances.
`timescale 1ns/1ps
module tb_ntt_rom_sched;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  st;
    logic [6:0]  idx;
  } pair_t;

  typedef struct {
    int    n;
    pair_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, abort8, ready8;
  logic [7:0]  addr1_8, addr2_8;
  logic [15:0] ra8, rb8, oa8, ob8;
  logic [2:0]  st8;
  logic [6:0]  idx8;
  logic        valid8, busy8, done8;

  logic        start1, abort1, ready1;
  logic [7:0]  addr1_1, addr2_1;
  logic [15:0] ra1, rb1, oa1, ob1;
  logic [2:0]  st1;
  logic [6:0]  idx1;
  logic        valid1, busy1, done1;

  int applied = 0;
  int miscompares = 0;
  int cyc = 0;
  pair_t q8[$];
  pair_t q1[$];
  int done8_cnt = 0, done8_cyc = 0, last8_cyc = 0;
  int done1_cnt = 0, done1_cyc = 0, last1_cyc = 0;

  ntt_rom_sched #(.STAGES(8), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
    .rom_addr1(addr1_8), .rom_addr2(addr2_8), .rom_a(ra8), .rom_b(rb8),
    .out_a(oa8), .out_b(ob8), .out_stage(st8), .out_idx(idx8),
    .out_valid(valid8), .out_ready(ready8), .busy(busy8), .done(done8)
  );

  ntt_rom_sched #(.STAGES(1), .DW(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .rom_addr1(addr1_1), .rom_addr2(addr2_1), .rom_a(ra1), .rom_b(rb1),
    .out_a(oa1), .out_b(ob1), .out_stage(st1), .out_idx(idx1),
    .out_valid(valid1), .out_ready(ready1), .busy(busy1), .done(done1)
  );

  // ROM contents mem[i] = i, one cycle read latency.
  always @(posedge clk) begin
    ra8 <= {8'h00, addr1_8};
    rb8 <= {8'h00, addr2_8};
    ra1 <= {8'h00, addr1_1};
    rb1 <= {8'h00, addr2_1};
  end

  always @(negedge clk) begin
    pair_t p;
    cyc = cyc + 1;
    if (rst_n && valid8 && ready8) begin
      p = {oa8, ob8, st8, idx8};
      q8.push_back(p);
      last8_cyc = cyc;
    end
    if (rst_n && done8) begin done8_cnt++; done8_cyc = cyc; end
    if (rst_n && valid1 && ready1) begin
      p = {oa1, ob1, st1, idx1};
      q1.push_back(p);
      last1_cyc = cyc;
    end
    if (rst_n && done1) begin done1_cnt++; done1_cyc = cyc; end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic pair_t ref_pair(input int s, input int k);
    int h, a1;
    pair_t p;
    h  = 1 << (7 - s);
    a1 = (k / h) * (2 * h) + (k % h);
    p.a = 16'(a1);
    p.b = 16'(a1 + h);
    p.st = 3'(s);
    p.idx = 7'(k);
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick_p(); @(posedge clk); #1; endtask
  task automatic tick_n(); @(negedge clk); #1; endtask

  task automatic compare_run(input string name, input pair_t got[$], input int stages);
    int bad = 0;
    int first = -1;
    int total = 128 * stages;
    pair_t e;
    chk({name, "_count"}, 64'(got.size()), 64'(total));
    for (int n = 0; n < got.size() && n < total; n++) begin
      e = ref_pair(n / 128, n % 128);
      if (got[n] !== e) begin
        bad++;
        if (first < 0) first = n;
      end
    end
    applied++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s_order: %0d bad pairs, first #%0d got %h want %h",
               name, bad, first, got[first], ref_pair(first / 128, first % 128));
    end
  endtask

  // Runs dut until its done pulse; rnd selects 50% random out_ready.
  task automatic run8_to_done(input string name, input bit rnd);
    int base = done8_cnt;
    int budget = 0;
    while (done8_cnt == base && budget < 5000) begin
      tick_p();
      ready8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      budget++;
    end
    ready8 = 1'b1;
    chk({name, "_done_seen"}, 64'(done8_cnt - base), 64'd1);
  endtask

  task automatic pulse_start8();
    tick_p(); start8 = 1'b1;
    tick_p(); start8 = 1'b0;
  endtask

  task automatic wait_count8(input string name, input int n);
    int budget = 0;
    while (q8.size() < n && budget < 5000) begin
      tick_p();
      budget++;
    end
    chk({name, "_reached"}, 64'(q8.size() >= n), 64'd1);
  endtask

  initial begin
    vec_t vecs[9];
    pair_t snap, cur;
    logic [7:0] a_frz;
    int bad, dc, budget;

    vecs[0] = '{0,    pair_t'({16'd0,   16'd128, 3'd0, 7'd0})};
    vecs[1] = '{5,    pair_t'({16'd5,   16'd133, 3'd0, 7'd5})};
    vecs[2] = '{128,  pair_t'({16'd0,   16'd64,  3'd1, 7'd0})};
    vecs[3] = '{129,  pair_t'({16'd1,   16'd65,  3'd1, 7'd1})};
    vecs[4] = '{192,  pair_t'({16'd128, 16'd192, 3'd1, 7'd64})};
    vecs[5] = '{356,  pair_t'({16'd196, 16'd228, 3'd2, 7'd100})};
    vecs[6] = '{394,  pair_t'({16'd10,  16'd26,  3'd3, 7'd10})};
    vecs[7] = '{901,  pair_t'({16'd10,  16'd11,  3'd7, 7'd5})};
    vecs[8] = '{1023, pair_t'({16'd254, 16'd255, 3'd7, 7'd127})};

    rst_n = 1'b0;
    start8 = 1'b0; abort8 = 1'b0; ready8 = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
    tick_n(); tick_n();
    chk("reset_outputs8", 64'({valid8, busy8, done8, addr1_8, addr2_8, oa8, ob8, st8, idx8}), 64'd0);
    chk("reset_outputs1", 64'({valid1, busy1, done1, addr1_1, addr2_1, oa1, ob1, st1, idx1}), 64'd0);
    tick_p(); rst_n = 1'b1;
    tick_n();
    chk("idle_after_reset", 64'({valid8, busy8, done8}), 64'd0);

    // First-pair latency, then a full 1024-pair run at full throughput.
    q8.delete();
    tick_p(); start8 = 1'b1;
    tick_p(); start8 = 1'b0;
    tick_n();
    chk("t1_addr", 64'({addr1_8, addr2_8, busy8, valid8}), 64'({8'd0, 8'd128, 1'b1, 1'b0}));
    tick_n();
    chk("t2_valid", 64'(valid8), 64'd0);
    tick_n();
    chk("t3_first_pair", 64'({valid8, oa8, ob8, st8, idx8}), 64'({1'b1, 16'd0, 16'd128, 3'd0, 7'd0}));
    run8_to_done("full", 1'b0);
    compare_run("full", q8, 8);
    for (int i = 0; i < 9; i++) begin
      cur = (vecs[i].n < q8.size()) ? q8[vecs[i].n] : '0;
      chk($sformatf("vec_pair_%0d", vecs[i].n), 64'(cur), 64'(vecs[i].exp));
    end
    chk("done_timing", 64'(done8_cyc - last8_cyc), 64'd1);
    tick_n();
    chk("done_pulse_end", 64'({done8, busy8, valid8}), 64'd0);

    // Back-pressure mid stage 3.
    q8.delete();
    pulse_start8();
    wait_count8("stall", 3*128 + 20);
    tick_p(); ready8 = 1'b0;
    tick_n();
    snap = {oa8, ob8, st8, idx8};
    a_frz = addr1_8;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick_n();
      cur = {oa8, ob8, st8, idx8};
      if (!valid8 || cur !== snap) bad++;
      if (i >= 2 && addr1_8 !== a_frz) bad++;
    end
    chk("stall_stable", 64'(bad), 64'd0);
    chk("stall_stage", 64'(snap.st), 64'd3);
    tick_p(); ready8 = 1'b1;
    run8_to_done("stall", 1'b0);
    compare_run("stall", q8, 8);

    // Random out_ready.
    q8.delete();
    pulse_start8();
    run8_to_done("random", 1'b1);
    compare_run("random", q8, 8);

    // Abort during stage 2, then restart.
    q8.delete();
    pulse_start8();
    budget = 0;
    while (q8.size() < 2*128 + 30 && budget < 5000) begin
      tick_p(); ready8 = 1'($urandom_range(0, 1)); budget++;
    end
    tick_p(); ready8 = 1'b1; abort8 = 1'b1;
    tick_p(); abort8 = 1'b0;
    tick_n();
    chk("abort_idle", 64'({busy8, valid8, done8, addr1_8, addr2_8}), 64'd0);
    dc = done8_cnt;
    repeat (10) tick_n();
    chk("abort_no_done", 64'(done8_cnt - dc), 64'd0);
    q8.delete();
    pulse_start8();
    run8_to_done("restart", 1'b0);
    compare_run("restart", q8, 8);

    // Reset asserted while draining.
    q8.delete();
    pulse_start8();
    budget = 0;
    while (!(busy8 && addr2_8 == 8'd0) && budget < 5000) begin
      tick_n(); budget++;
    end
    chk("drain_reached", 64'(busy8 && addr2_8 == 8'd0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_in_drain", 64'({valid8, busy8, done8, addr1_8, addr2_8, oa8, ob8, st8, idx8}), 64'd0);
    dc = done8_cnt;
    tick_p(); tick_p(); rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      tick_n();
      if (valid8 || busy8 || done8) bad++;
    end
    chk("post_reset_quiet", 64'(bad), 64'd0);
    chk("post_reset_no_done", 64'(done8_cnt - dc), 64'd0);

    // STAGES=1 instance.
    q1.delete();
    dc = done1_cnt;
    tick_p(); start1 = 1'b1;
    tick_p(); start1 = 1'b0;
    budget = 0;
    while (done1_cnt == dc && budget < 2000) begin
      tick_p(); budget++;
    end
    chk("s1_done_seen", 64'(done1_cnt - dc), 64'd1);
    compare_run("s1", q1, 1);
    cur = (q1.size() > 0) ? q1[q1.size()-1] : '0;
    chk("s1_last", 64'(cur), 64'({16'd127, 16'd255, 3'd0, 7'd127}));
    chk("s1_done_timing", 64'(done1_cyc - last1_cyc), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
